tinytester_phase_sequencer: RTL and testbench



---
 rtl/tinytester_phase_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_tinytester_phase_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinytester_phase_sequencer.sv
// Four-phase vector sequencer for the tinytester.
// Drives pad enables per phase and captures the DUT response.
module tinytester_phase_sequencer #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [31:0] control_i,
  input  logic [31:0] dataout_i,
  input  logic [31:0] oe_i,
  input  logic [31:0] active_on_p0_i,
  input  logic [31:0] active_on_p1_i,
  input  logic [31:0] active_on_p2_i,
  input  logic [31:0] active_on_p3_i,
  input  logic [31:0] pad_i,
  output logic [31:0] pad_o,
  output logic [31:0] pad_oe_o,
  output logic [31:0] datain_o,
  output logic [31:0] status_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_P3   = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [LEN_W-1:0] tick_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_in;
  logic [LEN_W-1:0] len_sel;
  logic [1:0]       cap_q;
  logic             cont_q;
  logic             stop_pend_q;
  logic             done_q;
  logic             ovr_q;
  logic             irq_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      datain_q;

  logic       busy;
  logic       start_ok;
  logic       last_tick;
  logic       end_vec;
  logic       stop_now;
  logic       go_idle;
  logic [1:0] phase;
  logic       unused_ctl;

  assign unused_ctl = ^control_i[31:11];

  assign busy      = (state_q != S_IDLE);
  assign start_ok  = start_i & ~busy;
  assign last_tick = busy & (tick_q == len_q - LEN_W'(1));
  assign end_vec   = (state_q == S_P3) & last_tick;
  // a stop arriving on the final tick still ends the run
  assign stop_now  = stop_pend_q | stop_i;
  assign go_idle   = end_vec & ~(cont_q & ~stop_now);

  assign len_in  = control_i[LEN_W-1:0];
  assign len_sel = (len_in == '0) ? LEN_W'(1) : len_in;

  assign pad_o    = dataout_i;
  assign datain_o = datain_q;
  assign irq_o    = irq_q;

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_P0;
      S_P0:   if (last_tick) state_d = S_P1;
      S_P1:   if (last_tick) state_d = S_P2;
      S_P2:   if (last_tick) state_d = S_P3;
      S_P3: begin
        if (last_tick) state_d = go_idle ? S_IDLE : S_P0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pad_oe_o = '0;
    phase    = 2'd0;
    unique case (1'b1)
      state_q == S_P0: begin
        pad_oe_o = oe_i & active_on_p0_i;
        phase    = 2'd0;
      end
      state_q == S_P1: begin
        pad_oe_o = oe_i & active_on_p1_i;
        phase    = 2'd1;
      end
      state_q == S_P2: begin
        pad_oe_o = oe_i & active_on_p2_i;
        phase    = 2'd2;
      end
      state_q == S_P3: begin
        pad_oe_o = oe_i & active_on_p3_i;
        phase    = 2'd3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      tick_q <= '0;
    end else if (start_ok) begin
      tick_q <= '0;
    end else if (busy) begin
      tick_q <= last_tick ? '0 : tick_q + LEN_W'(1);
    end
  end

  // run configuration is frozen at start
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      len_q  <= LEN_W'(1);
      cap_q  <= '0;
      cont_q <= 1'b0;
    end else if (start_ok) begin
      len_q  <= len_sel;
      cap_q  <= control_i[9:8];
      cont_q <= control_i[10] & ~stop_i;
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      done_q <= 1'b0;
    end else if (start_ok) begin
      done_q <= 1'b0;
    end else if (go_idle) begin
      done_q <= 1'b1;
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      ovr_q <= 1'b0;
    end else if (start_ok) begin
      ovr_q <= 1'b0;
    end else if (start_i && busy) begin
      ovr_q <= 1'b1;
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      stop_pend_q <= 1'b0;
    end else if (go_idle) begin
      stop_pend_q <= 1'b0;
    end else if (stop_i && busy) begin
      stop_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      irq_q <= end_vec;
      if (end_vec) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      datain_q <= '0;
    end else if (last_tick && (phase == cap_q)) begin
      datain_q <= pad_i;
    end
  end

  always_comb begin
    status_o              = '0;
    status_o[0]           = busy;
    status_o[1]           = done_q;
    status_o[3:2]         = phase;
    status_o[4]           = ovr_q;
    status_o[5]           = stop_pend_q;
    status_o[16 +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_tinytester_phase_sequencer.sv
// Bench for tinytester_phase_sequencer.
// Expected values come from a vector-position model of the run.
module tb_tinytester_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] control = '0;
  logic [31:0] dataout = '0;
  logic [31:0] oe = '0;
  logic [31:0] a0 = '0;
  logic [31:0] a1 = '0;
  logic [31:0] a2 = '0;
  logic [31:0] a3 = '0;
  logic [31:0] pad = '0;
  logic [31:0] pad_o;
  logic [31:0] pad_oe_o;
  logic [31:0] datain_o;
  logic [31:0] status_o;
  logic        irq_o;
  logic [128:0] got;

  int checks = 0;
  int errors = 0;

  bit          m_run, m_done, m_ovr, m_stop, m_cont, m_irq;
  int          m_pos, m_len, m_cap;
  logic [15:0] m_count;
  logic [31:0] m_data;

  tinytester_phase_sequencer dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_i      (rst),
    .start_i        (start),
    .stop_i         (stop),
    .control_i      (control),
    .dataout_i      (dataout),
    .oe_i           (oe),
    .active_on_p0_i (a0),
    .active_on_p1_i (a1),
    .active_on_p2_i (a2),
    .active_on_p3_i (a3),
    .pad_i          (pad),
    .pad_o          (pad_o),
    .pad_oe_o       (pad_oe_o),
    .datain_o       (datain_o),
    .status_o       (status_o),
    .irq_o          (irq_o)
  );

  assign got = {pad_o, status_o, pad_oe_o, datain_o, irq_o};

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_ovr = 0; m_stop = 0;
    m_cont = 0; m_irq = 0; m_pos = 0; m_len = 1;
    m_cap = 0; m_count = '0; m_data = '0;
  endtask

  // one vector is 4*len clocks; position within it gives phase and tick
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    m_irq = 0;
    if (!m_run) begin
      if (start) begin
        m_run  = 1;
        m_pos  = 0;
        m_len  = (control[7:0] == 0) ? 1 : int'(control[7:0]);
        m_cap  = int'(control[9:8]);
        m_cont = control[10] && !stop;
        m_done = 0;
        m_ovr  = 0;
      end
    end else begin
      if (start) m_ovr = 1;
      if (stop) m_stop = 1;
      if ((m_pos % m_len) == m_len - 1 && m_pos / m_len == m_cap)
        m_data = pad;
      if (m_pos == 4 * m_len - 1) begin
        m_count++;
        m_irq = 1;
        if (m_cont && !m_stop) m_pos = 0;
        else begin
          m_run = 0; m_done = 1; m_stop = 0;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  function automatic int m_phase();
    return m_run ? m_pos / m_len : 0;
  endfunction

  function automatic logic [128:0] exp_vec();
    logic [31:0] s;
    logic [31:0] e;
    s = '0;
    s[0] = m_run;
    s[1] = m_done;
    s[3:2] = 2'(m_phase());
    s[4] = m_ovr;
    s[5] = m_stop;
    s[31:16] = m_count;
    e = '0;
    if (m_run) begin
      case (m_phase())
        0: e = oe & a0;
        1: e = oe & a1;
        2: e = oe & a2;
        default: e = oe & a3;
      endcase
    end
    return {dataout, s, e, m_data, m_irq};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    dataout = $urandom;
    control = $urandom;
    oe = '1; a0 = '1; a1 = '1; a2 = '1; a3 = '1;
    rst = 1;
    cyc();
    cyc();
    checks++;
    if (got !== exp_vec()) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", got, exp_vec());
    end
    checks++;
    if (status_o !== 32'd0 || pad_oe_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_zero status=%h oe=%h exp 0", status_o, pad_oe_o);
    end
    rst = 0;
    cyc();
  endtask

  task automatic test_single();
    int busy_n = 0;
    int irq_n = 0;
    int oe_n = 0;
    control = 32'h0000_0203;
    oe = 32'hFF; a0 = 0; a1 = 32'h0F; a2 = 0; a3 = 0;
    dataout = $urandom;
    pad = $urandom;
    start = 1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      start = 0;
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL single cyc%0d got=%h exp=%h", i, got, exp_vec());
      end
      if (status_o[0]) busy_n++;
      if (irq_o) irq_n++;
      if (pad_oe_o == 32'h0F) oe_n++;
      pad = (m_run && m_phase() == 2) ? 32'hA5 : $urandom;
    end
    checks++;
    if (busy_n != 12 || irq_n != 1 || oe_n != 3) begin
      errors++;
      $display("FAIL single_timing busy=%0d irq=%0d oe=%0d exp 12 1 3",
               busy_n, irq_n, oe_n);
    end
    checks++;
    if (datain_o !== 32'hA5 || status_o !== 32'h0001_0002) begin
      errors++;
      $display("FAIL single_end datain=%h status=%h exp a5 00010002",
               datain_o, status_o);
    end
  endtask

  task automatic test_zero_len();
    int busy_n = 0;
    int irq_at = -1;
    control = ($urandom & 32'hFFFF_F800) | 32'h0000_0300;
    oe = $urandom; a0 = $urandom; a1 = $urandom;
    a2 = $urandom; a3 = $urandom;
    start = 1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      start = 0;
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL zero_len cyc%0d got=%h exp=%h", i, got, exp_vec());
      end
      if (status_o[0]) busy_n++;
      if (irq_o && irq_at < 0) irq_at = i;
      pad = $urandom;
    end
    checks++;
    if (busy_n != 4 || irq_at != 4) begin
      errors++;
      $display("FAIL zero_len_timing busy=%0d irq_at=%0d exp 4 4",
               busy_n, irq_at);
    end
  endtask

  task automatic test_cont_stop();
    int busy_n = 0;
    int irq_n = 0;
    bit sent = 0;
    logic [15:0] c0;
    c0 = m_count;
    control = 32'h0000_0401;
    oe = $urandom; a0 = $urandom; a1 = $urandom;
    a2 = $urandom; a3 = $urandom;
    start = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      start = 0;
      stop = 0;
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL cont_stop cyc%0d got=%h exp=%h", i, got, exp_vec());
      end
      if (status_o[0]) busy_n++;
      if (irq_o) irq_n++;
      pad = $urandom;
      if (!sent && m_run && m_count == c0 + 16'd2 && m_phase() == 1) begin
        stop = 1;
        sent = 1;
      end
      if (!m_run) break;
    end
    checks++;
    if (busy_n != 12 || irq_n != 3 || status_o[0] !== 1'b0 ||
        status_o[31:16] !== c0 + 16'd3) begin
      errors++;
      $display("FAIL cont_stop_sum busy=%0d irq=%0d st=%h exp 12 3 cnt+3",
               busy_n, irq_n, status_o);
    end
  endtask

  task automatic test_start_busy();
    int len;
    int busy_n = 0;
    len = $urandom_range(2, 5);
    control = 32'(len) | (32'($urandom_range(0, 3)) << 8);
    start = 1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      start = (i == len + 1);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL start_busy cyc%0d got=%h exp=%h", i, got, exp_vec());
      end
      if (status_o[0]) busy_n++;
      pad = $urandom;
      if (!m_run) break;
    end
    checks++;
    if (busy_n != 4 * len || status_o[4] !== 1'b1) begin
      errors++;
      $display("FAIL overrun busy=%0d ovr=%b exp %0d 1",
               busy_n, status_o[4], 4 * len);
    end
    start = 1;
    cyc();
    start = 0;
    checks++;
    if (status_o[4] !== 1'b0 || status_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_clear st=%h exp busy, ovr 0", status_o);
    end
    for (int i = 0; i < 24 && m_run; i++) cyc();
  endtask

  task automatic test_start_stop_idle();
    int busy_n = 0;
    int irq_n = 0;
    logic [15:0] c0;
    c0 = m_count;
    control = 32'h0000_0402;
    start = 1;
    stop = 1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      start = 0;
      stop = 0;
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL start_stop cyc%0d got=%h exp=%h", i, got, exp_vec());
      end
      if (status_o[0]) busy_n++;
      if (irq_o) irq_n++;
      if (i == 2) control[7:0] = 8'd7;
      if (!m_run) break;
    end
    checks++;
    if (busy_n != 8 || irq_n != 1 || status_o[31:16] !== c0 + 16'd1) begin
      errors++;
      $display("FAIL start_stop_sum busy=%0d irq=%0d st=%h exp 8 1",
               busy_n, irq_n, status_o);
    end
  endtask

  task automatic test_reset_mid();
    control = 32'h0000_0003 | (32'($urandom_range(0, 1)) << 8);
    oe = '1;
    a2 = $urandom | 32'h1;
    pad = $urandom | 32'h1;
    start = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      start = 0;
      if (m_run && m_phase() == 2) break;
    end
    checks++;
    if (pad_oe_o !== (oe & a2) || datain_o === 32'd0) begin
      errors++;
      $display("FAIL pre_reset oe=%h d=%h exp oe=%h d!=0",
               pad_oe_o, datain_o, oe & a2);
    end
    rst = 1;
    #1;
    checks++;
    if (pad_oe_o !== 32'd0 || status_o !== 32'd0 ||
        datain_o !== 32'd0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid oe=%h st=%h d=%h irq=%b exp 0",
               pad_oe_o, status_o, datain_o, irq_o);
    end
    cyc();
    rst = 0;
    cyc();
    checks++;
    if (got !== exp_vec() || status_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_random();
    control = 32'($urandom_range(0, 4)) | ($urandom & 32'h0000_0700);
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 15) == 0);
      pad = $urandom;
      if ($urandom_range(0, 19) == 0)
        control = 32'($urandom_range(0, 4)) | ($urandom & 32'hFFFF_FF00);
      if ($urandom_range(0, 29) == 0) begin
        dataout = $urandom; oe = $urandom;
        a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
      end
      cyc();
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    start = 0;
    stop = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_zero_len();
    test_cont_stop();
    test_start_busy();
    test_start_stop_idle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
